// File: rtl/sb_pkg.sv
// sb_pkg: shared types and helpers for the scoreboard hazard unit.
//   lat_class_e : latency class of the instruction in decode
//   lat_of()    : maps a latency class to the age at which its result is forwardable
//   FWD_RF      : forward-select encoding for "read the register file"
package sb_pkg;

    typedef enum logic [1:0] {
        LC_ALU  = 2'd0,
        LC_LOAD = 2'd1,
        LC_MUL  = 2'd2,
        LC_RSVD = 2'd3
    } lat_class_e;

    localparam int FWD_RF = 0;

    // LC_RSVD falls back to single-cycle ALU timing.
    function automatic int lat_of(lat_class_e lc, int load_lat, int mul_lat);
        case (lc)
            LC_LOAD: return load_lat;
            LC_MUL:  return mul_lat;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/scoreboard_hazard_unit_if.sv
// scoreboard_hazard_unit_if: decode-side bus of the scoreboard hazard unit.
//   master : decode stage (drives issue info, hold/flush; reads stall and selects)
//   slave  : hazard unit
// Optional macro SB_KILL_E_EN adds kill_e.
interface scoreboard_hazard_unit_if
    import sb_pkg::*;
#(
    parameter int NREGS   = 32,
    parameter int NSTAGES = 3,
    parameter int AW      = $clog2(NREGS),
    parameter int SW      = $clog2(NSTAGES + 1)
);
    logic              issue_valid;
    logic [AW-1:0]     rs1;
    logic [AW-1:0]     rs2;
    logic              rs1_use;
    logic              rs2_use;
    logic [AW-1:0]     rd;
    logic              rd_we;
    lat_class_e        lat_class;
    logic              hold;
    logic              flush_d;
`ifdef SB_KILL_E_EN
    logic              kill_e;
`endif
    logic              stall_d;
    logic [SW-1:0]     fwd_a_sel;
    logic [SW-1:0]     fwd_b_sel;
    logic [NREGS-1:0]  busy_vec;

    modport master (
        output issue_valid, rs1, rs2, rs1_use, rs2_use, rd, rd_we, lat_class,
               hold, flush_d,
`ifdef SB_KILL_E_EN
               kill_e,
`endif
        input  stall_d, fwd_a_sel, fwd_b_sel, busy_vec
    );

    modport slave (
        input  issue_valid, rs1, rs2, rs1_use, rs2_use, rd, rd_we, lat_class,
               hold, flush_d,
`ifdef SB_KILL_E_EN
               kill_e,
`endif
        output stall_d, fwd_a_sel, fwd_b_sel, busy_vec
    );

endinterface

// File: rtl/sb_entry.sv
// sb_entry: pending-write state for one architectural register.
//   clk, reset : clock, async active-high reset
//   hold       : freeze all state this edge
//   install    : new producer issued to this register (already gated by ~hold)
//   lat_in     : forwardable age of the new producer
//   kill       : (SB_KILL_E_EN only) drop an entry whose producer sits in E
//   busy/age/lat : current state
module sb_entry #(
    parameter int NSTAGES = 3,
    parameter int SW      = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold,
    input  logic          install,
    input  logic [SW-1:0] lat_in,
`ifdef SB_KILL_E_EN
    input  logic          kill,
`endif
    output logic          busy,
    output logic [SW-1:0] age,
    output logic [SW-1:0] lat
);
    logic          busy_q, busy_d;
    logic [SW-1:0] age_q, age_d;
    logic [SW-1:0] lat_q, lat_d;

    always_comb begin
        busy_d = busy_q;
        age_d  = age_q;
        lat_d  = lat_q;
        if (!hold) begin
            if (busy_q) begin
                // Age saturates at NSTAGES: that edge is the writeback, so retire.
                if (age_q == SW'(NSTAGES)) begin
                    busy_d = 1'b0;
                    age_d  = '0;
                    lat_d  = '0;
                end else begin
                    age_d = age_q + SW'(1);
                end
`ifdef SB_KILL_E_EN
                if (kill && age_q == SW'(1)) begin
                    busy_d = 1'b0;
                    age_d  = '0;
                    lat_d  = '0;
                end
`endif
            end
            // Newest producer owns the entry (WAW), overriding age/retire/kill.
            if (install) begin
                busy_d = 1'b1;
                age_d  = SW'(1);
                lat_d  = lat_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            age_q  <= '0;
            lat_q  <= '0;
        end else begin
            busy_q <= busy_d;
            age_q  <= age_d;
            lat_q  <= lat_d;
        end
    end

    assign busy = busy_q;
    assign age  = age_q;
    assign lat  = lat_q;

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit: per-register scoreboard producing the decode stall and
// operand forward selects for an NSTAGES-deep result pipeline.
//   clk, reset : clock, async active-high reset
//   sb         : slave side of scoreboard_hazard_unit_if (issue info in; stall_d,
//                fwd_a_sel/fwd_b_sel (0=regfile, k=stage k output), busy_vec out)
// Optional macro SB_KILL_E_EN: kill_e drops entries whose producer is in E.
module scoreboard_hazard_unit
    import sb_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int NSTAGES  = 3,
    parameter int LOAD_LAT = 2,
    parameter int MUL_LAT  = 3,
    parameter int AW       = $clog2(NREGS),
    parameter int SW       = $clog2(NSTAGES + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    scoreboard_hazard_unit_if.slave sb
);
    logic                  busy [NREGS];
    logic [SW-1:0]         age  [NREGS];
    logic [SW-1:0]         lat  [NREGS];
    logic [NREGS-1:0]      install;
    logic [SW-1:0]         lat_in;
    logic                  issue_fire;
    logic                  a_live, a_rdy, a_nrdy;
    logic                  b_live, b_rdy, b_nrdy;

    assign lat_in = SW'(lat_of(sb.lat_class, LOAD_LAT, MUL_LAT));

    // Register 0 is hard-wired zero and never tracked.
    assign busy[0]       = 1'b0;
    assign age[0]        = '0;
    assign lat[0]        = '0;
    assign install[0]    = 1'b0;
    assign sb.busy_vec[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_ent
            assign install[gi] = issue_fire && sb.rd_we && (sb.rd == AW'(gi));
            sb_entry #(.NSTAGES(NSTAGES), .SW(SW)) u_ent (
                .clk     (clk),
                .reset   (reset),
                .hold    (sb.hold),
                .install (install[gi]),
                .lat_in  (lat_in),
`ifdef SB_KILL_E_EN
                .kill    (sb.kill_e),
`endif
                .busy    (busy[gi]),
                .age     (age[gi]),
                .lat     (lat[gi])
            );
            assign sb.busy_vec[gi] = busy[gi];
        end
    endgenerate

    // Operand lookup: a busy source forwards once its age reaches its latency.
    assign a_live = sb.rs1_use && (sb.rs1 != '0) && busy[sb.rs1];
    assign a_rdy  = age[sb.rs1] >= lat[sb.rs1];
    assign a_nrdy = a_live && !a_rdy;
    assign b_live = sb.rs2_use && (sb.rs2 != '0) && busy[sb.rs2];
    assign b_rdy  = age[sb.rs2] >= lat[sb.rs2];
    assign b_nrdy = b_live && !b_rdy;

    assign sb.fwd_a_sel = (a_live && a_rdy) ? age[sb.rs1] : SW'(FWD_RF);
    assign sb.fwd_b_sel = (b_live && b_rdy) ? age[sb.rs2] : SW'(FWD_RF);

    // A redirect kills the D instruction, so it never needs to stall.
    assign sb.stall_d  = sb.issue_valid && !sb.flush_d && (a_nrdy || b_nrdy);
    assign issue_fire  = sb.issue_valid && !sb.stall_d && !sb.flush_d && !sb.hold;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench for scoreboard_hazard_unit (defaults: 32 regs, 3 stages,
// LOAD_LAT=2, MUL_LAT=3). Inputs change 1ns after a rising edge, outputs are
// checked 1ns later.
module tb_scoreboard_hazard_unit;
    import sb_pkg::*;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    scoreboard_hazard_unit_if #(.NREGS(32), .NSTAGES(3)) sbi ();

    scoreboard_hazard_unit #(
        .NREGS(32), .NSTAGES(3), .LOAD_LAT(2), .MUL_LAT(3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sbi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ins(input logic v, input logic [4:0] r1, input logic u1,
                           input logic [4:0] r2, input logic u2,
                           input logic [4:0] d, input logic we, input lat_class_e lc);
        sbi.issue_valid = v;
        sbi.rs1 = r1;  sbi.rs1_use = u1;
        sbi.rs2 = r2;  sbi.rs2_use = u2;
        sbi.rd  = d;   sbi.rd_we   = we;
        sbi.lat_class = lc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        set_ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, LC_ALU);
        repeat (4) tick();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        sbi.hold = 1'b0;
        sbi.flush_d = 1'b0;
`ifdef SB_KILL_E_EN
        sbi.kill_e = 1'b0;
`endif
        set_ins(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd5, 1'b1, LC_LOAD);
        #1;
        chk("rst_stall", {31'd0, sbi.stall_d}, 32'd0);
        chk("rst_busy", sbi.busy_vec, 32'd0);
        chk("rst_fwda", {30'd0, sbi.fwd_a_sel}, 32'd0);
        tick();
        tick();
        set_ins(1'b0, 5'd5, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, LC_ALU);
        reset = 1'b0;
        #1;
        chk("post_rst_stall", {31'd0, sbi.stall_d}, 32'd0);
        chk("post_rst_busy", sbi.busy_vec, 32'd0);
        chk("post_rst_fwdb", {30'd0, sbi.fwd_b_sel}, 32'd0);
        tick();

        // ALU r5 forwarded from E, M, W then retired
        set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, LC_ALU);
        #1 chk("alu_issue_stall", {31'd0, sbi.stall_d}, 32'd0);
        tick();
        set_ins(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, LC_ALU);
        #1;
        chk("alu_stall", {31'd0, sbi.stall_d}, 32'd0);
        chk("alu_fwd1", {30'd0, sbi.fwd_a_sel}, 32'd1);
        tick();
        chk("alu_fwd2", {30'd0, sbi.fwd_a_sel}, 32'd2);
        tick();
        chk("alu_fwd3", {30'd0, sbi.fwd_a_sel}, 32'd3);
        chk("alu_busy5", {31'd0, sbi.busy_vec[5]}, 32'd1);
        tick();
        chk("alu_retired", {31'd0, sbi.busy_vec[5]}, 32'd0);
        chk("alu_fwd_rf", {30'd0, sbi.fwd_a_sel}, 32'd0);
        drain();

        // LOAD r7, load-use on rs2: one stall then M forward
        set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, LC_LOAD);
        tick();
        set_ins(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, LC_ALU);
        #1;
        chk("ld_stall", {31'd0, sbi.stall_d}, 32'd1);
        chk("ld_fwd_hold", {30'd0, sbi.fwd_b_sel}, 32'd0);
        tick();
        chk("ld_nostall", {31'd0, sbi.stall_d}, 32'd0);
        chk("ld_fwd2", {30'd0, sbi.fwd_b_sel}, 32'd2);
        drain();

        // MUL r3: two stalls then W forward
        set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, LC_MUL);
        tick();
        set_ins(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, LC_ALU);
        #1 chk("mul_stall1", {31'd0, sbi.stall_d}, 32'd1);
        tick();
        chk("mul_stall2", {31'd0, sbi.stall_d}, 32'd1);
        tick();
        chk("mul_nostall", {31'd0, sbi.stall_d}, 32'd0);
        chk("mul_fwd3", {30'd0, sbi.fwd_a_sel}, 32'd3);
        drain();

        // WAW: ALU r4 then LOAD r4, reader sees the load
        set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, LC_ALU);
        tick();
        set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, LC_LOAD);
        tick();
        set_ins(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, LC_ALU);
        #1;
        chk("waw_stall", {31'd0, sbi.stall_d}, 32'd1);
        chk("waw_fwd0", {30'd0, sbi.fwd_a_sel}, 32'd0);
        tick();
        chk("waw_nostall", {31'd0, sbi.stall_d}, 32'd0);
        chk("waw_fwd2", {30'd0, sbi.fwd_a_sel}, 32'd2);
        drain();

        // Hold freezes aging of LOAD r9
        set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, LC_LOAD);
        tick();
        set_ins(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, LC_ALU);
        sbi.hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("hold_stall", {31'd0, sbi.stall_d}, 32'd1);
            chk("hold_busy9", {31'd0, sbi.busy_vec[9]}, 32'd1);
            tick();
        end
        sbi.hold = 1'b0;
        #1 chk("hold_rel_stall", {31'd0, sbi.stall_d}, 32'd1);
        tick();
        chk("hold_rel_nostall", {31'd0, sbi.stall_d}, 32'd0);
        chk("hold_rel_fwd2", {30'd0, sbi.fwd_a_sel}, 32'd2);
        drain();

        // r0 is never tracked and never stalls
        set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, LC_LOAD);
        tick();
        set_ins(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, LC_ALU);
        #1;
        chk("r0_stall", {31'd0, sbi.stall_d}, 32'd0);
        chk("r0_busy", sbi.busy_vec, 32'd0);
        drain();

        // Unused operand ignores hazard; flush forces stall_d=0 and blocks issue
        set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, LC_MUL);
        tick();
        set_ins(1'b1, 5'd6, 1'b0, 5'd6, 1'b0, 5'd0, 1'b0, LC_ALU);
        #1 chk("nouse_stall", {31'd0, sbi.stall_d}, 32'd0);
        set_ins(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, LC_ALU);
        #1 chk("hazard_stall", {31'd0, sbi.stall_d}, 32'd1);
        sbi.flush_d = 1'b1;
        #1 chk("flush_stall", {31'd0, sbi.stall_d}, 32'd0);
        tick();
        sbi.flush_d = 1'b0;
        chk("flush_noinst", {31'd0, sbi.busy_vec[8]}, 32'd0);
        drain();

        // Async reset drops a pending entry immediately
        set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, LC_LOAD);
        tick();
        set_ins(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, LC_ALU);
        #1;
        chk("pre_rst_busy9", {31'd0, sbi.busy_vec[9]}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", sbi.busy_vec, 32'd0);
        chk("mid_rst_stall", {31'd0, sbi.stall_d}, 32'd0);
        tick();
        reset = 1'b0;
        drain();

`ifdef SB_KILL_E_EN
        // kill_e drops the age-1 entry
        set_ins(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, LC_LOAD);
        tick();
        set_ins(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, LC_ALU);
        sbi.kill_e = 1'b1;
        tick();
        sbi.kill_e = 1'b0;
        chk("kill_busy2", {31'd0, sbi.busy_vec[2]}, 32'd0);
        set_ins(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, LC_ALU);
        #1;
        chk("kill_fwd", {30'd0, sbi.fwd_a_sel}, 32'd0);
        chk("kill_stall", {31'd0, sbi.stall_d}, 32'd0);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
